// File: rtl/latch_bank_writer.sv
// Drives one (addr, data) write into a latch bank: data goes on the bus, then the one-hot crit pulses, then data is held.
// A write finishes SETUP_CYC+CRIT_CYC+HOLD_CYC edges after acceptance; wrReady is low for that whole time.
module latch_bank_writer #(
  parameter int WIDTH       = 8,
  parameter int NUM_LATCHES = 4,
  parameter int SETUP_CYC   = 2,
  parameter int CRIT_CYC    = 3,
  parameter int HOLD_CYC    = 2,
  localparam int AW = (NUM_LATCHES > 1) ? $clog2(NUM_LATCHES) : 1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   wrValid,
  output logic                   wrReady,
  input  logic [AW-1:0]          wrAddr,
  input  logic [WIDTH-1:0]       wrData,
  output logic [WIDTH-1:0]       dataOut,
  output logic [NUM_LATCHES-1:0] crit,
  output logic                   busy,
  output logic                   done,
  output logic                   badAddr
);

  localparam int MAXC = (SETUP_CYC > CRIT_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((CRIT_CYC > HOLD_CYC) ? CRIT_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXC) + 1;

  // Each phase counter loads (length - 1) on entry and the phase ends when it reaches zero.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] CRIT_LD  = CW'(CRIT_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    CRIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                   state;
  state_t                   nextState;
  logic [CW-1:0]            phaseCnt;
  logic [CW-1:0]            cntNext;
  logic [AW-1:0]            addrQ;
  logic                     addrBadQ;
  logic                     wrAddrBad;
  logic                     accept;
  logic                     phaseEnd;
  logic [WIDTH-1:0]         dataNext;
  logic [NUM_LATCHES-1:0]   critNext;
  logic                     busyNext;
  logic                     doneNext;
  logic                     badNext;

  assign wrReady   = (state == IDLE) && resetN;
  assign accept    = wrValid && wrReady;
  assign phaseEnd  = (phaseCnt == '0);
  assign wrAddrBad = (32'(wrAddr) >= NUM_LATCHES);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state    <= IDLE;
      phaseCnt <= '0;
      addrQ    <= '0;
      addrBadQ <= 1'b0;
      dataOut  <= '0;
      crit     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      badAddr  <= 1'b0;
    end else begin
      state    <= nextState;
      phaseCnt <= cntNext;
      if (accept) begin
        addrQ    <= wrAddr;
        addrBadQ <= wrAddrBad;
      end
      dataOut  <= dataNext;
      crit     <= critNext;
      busy     <= busyNext;
      done     <= doneNext;
      badAddr  <= badNext;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept)   nextState = SETUP;
      SETUP:   if (phaseEnd) nextState = CRIT;
      CRIT:    if (phaseEnd) nextState = HOLD;
      HOLD:    if (phaseEnd) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    cntNext = phaseCnt;
    if (nextState != state) begin
      case (nextState)
        SETUP:   cntNext = SETUP_LD;
        CRIT:    cntNext = CRIT_LD;
        HOLD:    cntNext = HOLD_LD;
        default: cntNext = '0;
      endcase
    end else if (!phaseEnd) begin
      cntNext = phaseCnt - CW'(1);
    end

    // Bus only moves on acceptance, so it is frozen through CRIT and HOLD.
    dataNext = accept ? wrData : dataOut;

    // An out-of-range address runs the full sequence with every enable held low.
    critNext = '0;
    if (nextState == CRIT && !addrBadQ) begin
      for (int i = 0; i < NUM_LATCHES; i++) begin
        critNext[i] = (32'(addrQ) == i);
      end
    end

    busyNext = (nextState != IDLE);
    doneNext = (state == HOLD) && phaseEnd;
    badNext  = doneNext && addrBadQ;
  end

endmodule

// File: tb/tb_latch_bank_writer.sv
// Scoreboard bench for latch_bank_writer: a 4-latch and a 3-latch instance share stimulus, selected by sel.
module tb_latch_bank_writer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN;
  logic       wrValid;
  logic       sel;
  logic [1:0] wrAddr;
  logic [7:0] wrData;
  logic       monOn = 1'b0;

  logic       wrReadyA, busyA, doneA, badA;
  logic [7:0] dataOutA;
  logic [3:0] critA;
  logic       wrReadyB, busyB, doneB, badB;
  logic [7:0] dataOutB;
  logic [2:0] critB;

  latch_bank_writer dut (
    .clk(clk), .resetN(resetN), .wrValid(wrValid && !sel), .wrReady(wrReadyA),
    .wrAddr(wrAddr), .wrData(wrData), .dataOut(dataOutA), .crit(critA),
    .busy(busyA), .done(doneA), .badAddr(badA)
  );

  latch_bank_writer #(.NUM_LATCHES(3)) dut3 (
    .clk(clk), .resetN(resetN), .wrValid(wrValid && sel), .wrReady(wrReadyB),
    .wrAddr(wrAddr), .wrData(wrData), .dataOut(dataOutB), .crit(critB),
    .busy(busyB), .done(doneB), .badAddr(badB)
  );

  logic       mReady, mBusy, mDone, mBad;
  logic [7:0] mData;
  logic [3:0] mCrit;
  assign mReady = sel ? wrReadyB : wrReadyA;
  assign mBusy  = sel ? busyB : busyA;
  assign mDone  = sel ? doneB : doneA;
  assign mBad   = sel ? badB : badA;
  assign mData  = sel ? dataOutB : dataOutA;
  assign mCrit  = sel ? {1'b0, critB} : critA;

  typedef struct {
    logic [7:0] data;
    logic [3:0] critv;
    logic       bad;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   viol = 1'b0;
  logic rstEdge = 1'b0;

  always @(posedge clk) rstEdge <= !resetN;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: tracks each busy window and compares against the scoreboard on every done pulse.
  initial begin
    int         busyCnt = 0;
    int         critStart = -1;
    int         critLen = 0;
    logic [3:0] critSeen = '0;
    logic [3:0] prevCrit = '0;
    logic [7:0] prevData = '0;
    exp_t       e;
    wait (monOn);
    forever begin
      @(negedge clk);
      if (!rstEdge) begin
        if (mCrit != prevCrit && mData != prevData) viol = 1'b1;
        if (!$onehot0(mCrit)) viol = 1'b1;
        if (!mBusy && mCrit != 4'b0) viol = 1'b1;
        if (mBusy && busyCnt != 0 && mData != prevData) viol = 1'b1;
      end
      if (mBad) check("badWithDone", 32'(mDone), 32'd1);
      if (mBusy) begin
        if (mCrit != 4'b0) begin
          if (critLen == 0) critStart = busyCnt;
          critLen++;
          critSeen = mCrit;
        end
        busyCnt++;
      end else begin
        if (mDone) begin
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpectedDone: got done=1, expected no pending write");
          end else begin
            e = q.pop_front();
            check("doneLatency", 32'(busyCnt), 32'd7);
            check("doneData", 32'(mData), 32'(e.data));
            check("doneBadAddr", 32'(mBad), 32'(e.bad));
            check("critValue", 32'(critSeen), 32'(e.critv));
            check("critLength", 32'(critLen), (e.critv != 4'b0) ? 32'd3 : 32'd0);
            if (e.critv != 4'b0) check("critStart", 32'(critStart), 32'd2);
            check("invariants", 32'(viol), 32'd0);
            viol = 1'b0;
          end
        end
        busyCnt   = 0;
        critStart = -1;
        critLen   = 0;
        critSeen  = '0;
      end
      prevCrit = mCrit;
      prevData = mData;
    end
  end

  // Waits for wrReady, then pushes the hand-computed expectation once the acceptance edge passes.
  task automatic doWrite(input bit s, input logic [1:0] a, input logic [7:0] d,
                         input logic [7:0] eData, input logic [3:0] eCrit,
                         input bit eBad, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    sel = s; wrValid = 1'b1; wrAddr = a; wrData = d;
    #1;
    while (!mReady && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL acceptTimeout: got wrReady=0 for 50 cycles, expected 1");
      wrValid = 1'b0;
      return;
    end
    @(posedge clk);
    e.data = eData; e.critv = eCrit; e.bad = eBad;
    if (push) q.push_back(e);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (mBusy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL idleTimeout: got busy=1 for 40 cycles, expected 0");
    end
    @(negedge clk);
  endtask

  initial begin
    time t0, t1;
    int  n;
    resetN = 1'b0; wrValid = 1'b1; wrAddr = 2'd1; wrData = 8'hFF; sel = 1'b0;

    // Scenario 1: reset held with a pending request.
    repeat (3) begin
      @(posedge clk); #1;
      check("rstDataOut", 32'(dataOutA), 32'h0);
      check("rstCrit", 32'(critA), 32'h0);
      check("rstDone", 32'(doneA), 32'h0);
      check("rstBusy", 32'(busyA), 32'h0);
      check("rstWrReady", 32'(wrReadyA), 32'h0);
    end
    @(negedge clk);
    wrValid = 1'b0; resetN = 1'b1; monOn = 1'b1;
    #1 check("readyAfterRst", 32'(wrReadyA), 32'h1);

    // Scenario 2: basic write.
    doWrite(1'b0, 2'd2, 8'hA5, 8'hA5, 4'b0100, 1'b0, 1'b1);
    #1 check("dataAtAccept", 32'(dataOutA), 32'hA5);
    check("busyAtAccept", 32'(busyA), 32'h1);
    @(negedge clk); wrValid = 1'b0;
    waitIdle();

    // Scenario 3: held wrValid, second request taken in the done cycle.
    doWrite(1'b0, 2'd0, 8'h11, 8'h11, 4'b0001, 1'b0, 1'b1);
    t0 = $time;
    doWrite(1'b0, 2'd3, 8'hC3, 8'hC3, 4'b1000, 1'b0, 1'b1);
    t1 = $time;
    check("b2bSpacing", 32'((t1 - t0) / 10), 32'd8);
    @(negedge clk); wrValid = 1'b0;
    waitIdle();

    // Scenario 6: new requests while busy are ignored.
    doWrite(1'b0, 2'd1, 8'h5C, 8'h5C, 4'b0010, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk); wrValid = 1'b1; wrAddr = 2'd3; wrData = 8'hFF;
    end
    @(negedge clk); wrValid = 1'b0;
    waitIdle();
    check("ignoredHold", 32'(dataOutA), 32'h5C);

    // Scenario 4: out-of-range address on the 3-latch instance, then an in-range one.
    doWrite(1'b1, 2'd3, 8'h3C, 8'h3C, 4'b0000, 1'b1, 1'b1);
    @(negedge clk); wrValid = 1'b0;
    waitIdle();
    doWrite(1'b1, 2'd2, 8'h77, 8'h77, 4'b0100, 1'b0, 1'b1);
    @(negedge clk); wrValid = 1'b0;
    waitIdle();

    // Scenario 5: reset during the second CRIT cycle aborts without done.
    doWrite(1'b0, 2'd2, 8'h5A, 8'h5A, 4'b0100, 1'b0, 1'b0);
    @(negedge clk); wrValid = 1'b0;
    repeat (3) @(negedge clk);
    check("critBeforeAbort", 32'(critA), 32'h4);
    resetN = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    #1;
    check("abortCrit", 32'(critA), 32'h0);
    check("abortDataOut", 32'(dataOutA), 32'h0);
    check("abortWrReady", 32'(wrReadyA), 32'h1);
    check("abortBusy", 32'(busyA), 32'h0);
    repeat (10) @(negedge clk);
    doWrite(1'b0, 2'd2, 8'hA5, 8'hA5, 4'b0100, 1'b0, 1'b1);
    @(negedge clk); wrValid = 1'b0;
    waitIdle();

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queueDrained", 32'(q.size()), 32'd0);
    check("finalInvariants", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
